// File: rtl/avalon_mem_if_almfull_rx.sv
// Almost-full Avalon-MM request terminator: a FIFO absorbs requests that arrive after
// afu_waitrequest rises and replays them to a strict-waitrequest slave.
module avalon_mem_if_almfull_rx #(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned SLACK           = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  // upstream (AFU) side
  input  logic [ADDR_WIDTH-1:0]      afu_address,
  input  logic [BURST_CNT_WIDTH-1:0] afu_burstcount,
  input  logic [DATA_WIDTH-1:0]      afu_writedata,
  input  logic [DATA_WIDTH/8-1:0]    afu_byteenable,
  input  logic                       afu_read,
  input  logic                       afu_write,
  output logic                       afu_waitrequest,
  output logic [DATA_WIDTH-1:0]      afu_readdata,
  output logic                       afu_readdatavalid,
  // downstream (memory) side
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic [BURST_CNT_WIDTH-1:0] mem_burstcount,
  output logic [DATA_WIDTH-1:0]      mem_writedata,
  output logic [DATA_WIDTH/8-1:0]    mem_byteenable,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic                       mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]      mem_readdata,
  input  logic                       mem_readdatavalid,
  // status
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow_err,
  output logic                       protocol_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]      addr_mem  [DEPTH];
  logic [BURST_CNT_WIDTH-1:0] burst_mem [DEPTH];
  logic [DATA_WIDTH-1:0]      data_mem  [DEPTH];
  logic [BeW-1:0]             be_mem    [DEPTH];
  logic                       wr_mem    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] occ_q, occ_d;
  logic            req, full, not_empty, push, pop;

  assign req       = afu_read | afu_write;
  assign full      = (occ_q == CntW'(DEPTH));
  assign not_empty = (occ_q != '0);
  assign pop       = not_empty & ~mem_waitrequest;
  // When full, a simultaneous pop frees the slot being written, so the push is accepted.
  assign push      = req & (~full | pop);

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + CntW'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      occ_q             <= '0;
      afu_waitrequest   <= 1'b1;
      afu_readdatavalid <= 1'b0;
      overflow_err      <= 1'b0;
      protocol_err      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      occ_q             <= occ_d;
      afu_waitrequest   <= (occ_d >= CntW'(DEPTH - SLACK));
      afu_readdatavalid <= mem_readdatavalid;
      if (req && !push) begin
        overflow_err <= 1'b1;
      end
      if (afu_read && afu_write) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // Storage and response data carry no reset; they are qualified by valid/occupancy.
  always_ff @(posedge clk) begin
    afu_readdata <= mem_readdata;
    if (push) begin
      addr_mem[wr_ptr_q]  <= afu_address;
      burst_mem[wr_ptr_q] <= afu_burstcount;
      data_mem[wr_ptr_q]  <= afu_writedata;
      be_mem[wr_ptr_q]    <= afu_byteenable;
      wr_mem[wr_ptr_q]    <= afu_write;
    end
  end

  assign mem_address    = addr_mem[rd_ptr_q];
  assign mem_burstcount = burst_mem[rd_ptr_q];
  assign mem_writedata  = data_mem[rd_ptr_q];
  assign mem_byteenable = be_mem[rd_ptr_q];
  assign mem_read       = ~reset & not_empty & ~wr_mem[rd_ptr_q];
  assign mem_write      = ~reset & not_empty & wr_mem[rd_ptr_q];
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_avalon_mem_if_almfull_rx.sv
// Scoreboard bench: stimulus queues expected memory requests and read responses; a monitor
// pops and compares them on every downstream handshake and upstream response.
module tb_avalon_mem_if_almfull_rx;

  localparam int unsigned AW = 27;
  localparam int unsigned DW = 512;
  localparam int unsigned BW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] afu_address;
  logic [BW-1:0] afu_burstcount;
  logic [DW-1:0] afu_writedata;
  logic [DW/8-1:0] afu_byteenable;
  logic          afu_read, afu_write;
  logic          afu_waitrequest;
  logic [DW-1:0] afu_readdata;
  logic          afu_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_burstcount;
  logic [DW-1:0] mem_writedata;
  logic [DW/8-1:0] mem_byteenable;
  logic          mem_read, mem_write;
  logic          mem_waitrequest;
  logic [DW-1:0] mem_readdata;
  logic          mem_readdatavalid;
  logic [4:0]    occupancy;
  logic          overflow_err, protocol_err;

  avalon_mem_if_almfull_rx dut (
    .clk               (clk),
    .reset             (reset),
    .afu_address       (afu_address),
    .afu_burstcount    (afu_burstcount),
    .afu_writedata     (afu_writedata),
    .afu_byteenable    (afu_byteenable),
    .afu_read          (afu_read),
    .afu_write         (afu_write),
    .afu_waitrequest   (afu_waitrequest),
    .afu_readdata      (afu_readdata),
    .afu_readdatavalid (afu_readdatavalid),
    .mem_address       (mem_address),
    .mem_burstcount    (mem_burstcount),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .occupancy         (occupancy),
    .overflow_err      (overflow_err),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [BW-1:0] burst;
    logic [63:0]   data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] resp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] b, input logic [63:0] d);
    afu_read       = rd;
    afu_write      = wr;
    afu_address    = a;
    afu_burstcount = b;
    afu_writedata  = {8{d}};
    afu_byteenable = '1;
  endtask

  task automatic idle();
    afu_read  = 1'b0;
    afu_write = 1'b0;
  endtask

  task automatic expect_req(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic [63:0] d);
    exp_t e;
    e.w = w;
    e.addr = a;
    e.burst = b;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every accepted downstream request and every upstream response.
  initial begin
    exp_t        e;
    logic [63:0] r;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_forces_idle", {62'd0, mem_read, mem_write}, 64'd0);
      end else if ((mem_read || mem_write) && !mem_waitrequest) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: addr %0h with no request outstanding at %0t",
                   mem_address, $time);
        end else begin
          e = exp_q.pop_front();
          check("req_onehot", {63'd0, mem_read & mem_write}, 64'd0);
          check("req_is_write", {63'd0, mem_write}, {63'd0, e.w});
          check("req_addr", {37'd0, mem_address}, {37'd0, e.addr});
          check("req_burst", {57'd0, mem_burstcount}, {57'd0, e.burst});
          if (e.w) begin
            check("req_wdata", mem_writedata[63:0], e.data);
            check("req_wdata_full", {63'd0, mem_writedata == {8{e.data}}}, 64'd1);
            check("req_be", {63'd0, &mem_byteenable}, 64'd1);
          end
        end
      end
      if (!reset && afu_readdatavalid) begin
        if (resp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: data %0h with no response pending at %0t",
                   afu_readdata[63:0], $time);
        end else begin
          r = resp_q.pop_front();
          check("resp_data_full", {63'd0, afu_readdata == {8{r}}}, 64'd1);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    drive(1'b0, 1'b0, '0, '0, '0);

    // Reset state
    step();
    step();
    check("rst_waitreq", {63'd0, afu_waitrequest}, 64'd1);
    check("rst_occ", {59'd0, occupancy}, 64'd0);
    check("rst_rdvalid", {63'd0, afu_readdatavalid}, 64'd0);
    check("rst_errs", {62'd0, overflow_err, protocol_err}, 64'd0);
    reset = 1'b0;
    step();
    check("waitreq_after_rst", {63'd0, afu_waitrequest}, 64'd0);

    // 1: write then read, 1-cycle request latency, 1-cycle response stage
    drive(1'b0, 1'b1, 27'h10, 7'd1, 64'hAA);
    expect_req(1'b1, 27'h10, 7'd1, 64'hAA);
    step();
    check("t1_write_cyc1", {62'd0, mem_write, mem_read}, 64'd2);
    drive(1'b1, 1'b0, 27'h10, 7'd1, 64'h0);
    expect_req(1'b0, 27'h10, 7'd1, 64'h0);
    step();
    idle();
    check("t1_read_cyc2", {62'd0, mem_write, mem_read}, 64'd1);
    step();
    mem_readdatavalid = 1'b1;
    mem_readdata = {8{64'hAA}};
    resp_q.push_back(64'hAA);
    check("t1_resp_not_yet", {63'd0, afu_readdatavalid}, 64'd0);
    step();
    mem_readdatavalid = 1'b0;
    check("t1_resp_k1", {63'd0, afu_readdatavalid}, 64'd1);

    // 2: fill against a stalled slave
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, AW'(27'h100 + i), 7'd1, 64'(i));
      expect_req(1'b1, AW'(27'h100 + i), 7'd1, 64'(i));
      step();
      if (i == 8) check("t2_waitreq_9", {63'd0, afu_waitrequest}, 64'd0);
    end
    check("t2_waitreq_10", {63'd0, afu_waitrequest}, 64'd1);
    check("t2_occ_10", {59'd0, occupancy}, 64'd10);
    for (int i = 10; i < 16; i++) begin
      drive(1'b0, 1'b1, AW'(27'h100 + i), 7'd1, 64'(i));
      expect_req(1'b1, AW'(27'h100 + i), 7'd1, 64'(i));
      step();
    end
    idle();
    check("t2_occ_16", {59'd0, occupancy}, 64'd16);
    check("t2_no_ovf", {63'd0, overflow_err}, 64'd0);

    // 3: push+pop while full is legal; push while full and stalled is dropped
    mem_waitrequest = 1'b0;
    drive(1'b0, 1'b1, 27'h1FF, 7'd1, 64'h55);
    expect_req(1'b1, 27'h1FF, 7'd1, 64'h55);
    step();
    mem_waitrequest = 1'b1;
    idle();
    check("t3_pushpop_occ", {59'd0, occupancy}, 64'd16);
    check("t3_pushpop_no_ovf", {63'd0, overflow_err}, 64'd0);
    drive(1'b0, 1'b1, 27'h1EE, 7'd1, 64'h66);
    step();
    idle();
    check("t3_drop_occ", {59'd0, occupancy}, 64'd16);
    check("t3_ovf_set", {63'd0, overflow_err}, 64'd1);
    mem_waitrequest = 1'b0;
    repeat (15) step();
    check("t2_drain_occ_15", {59'd0, occupancy}, 64'd1);
    step();
    check("t2_drain_occ_16", {59'd0, occupancy}, 64'd0);
    check("t2_waitreq_low", {63'd0, afu_waitrequest}, 64'd0);
    check("t3_ovf_sticky", {63'd0, overflow_err}, 64'd1);
    check("t2_all_issued", 64'(exp_q.size()), 64'd0);

    // 4: 4-beat write burst against a toggling waitrequest
    for (int i = 0; i < 4; i++) begin
      mem_waitrequest = (i % 2 == 0);
      drive(1'b0, 1'b1, AW'(27'h200 + i), 7'd4, 64'(64'hB0 + i));
      expect_req(1'b1, AW'(27'h200 + i), 7'd4, 64'(64'hB0 + i));
      step();
    end
    idle();
    mem_waitrequest = 1'b0;
    repeat (4) step();
    check("t4_occ", {59'd0, occupancy}, 64'd0);
    check("t4_all_beats", 64'(exp_q.size()), 64'd0);

    // 5: reset mid-operation with 5 buffered reads
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, AW'(27'h300 + i), 7'd1, 64'h0);
      step();
    end
    idle();
    check("t5_occ_5", {59'd0, occupancy}, 64'd5);
    reset = 1'b1;
    #1;
    check("t5_rst_comb", {62'd0, mem_read, mem_write}, 64'd0);
    step();
    step();
    check("t5_rst_occ", {59'd0, occupancy}, 64'd0);
    check("t5_rst_waitreq", {63'd0, afu_waitrequest}, 64'd1);
    check("t5_rst_ovf", {63'd0, overflow_err}, 64'd0);
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    step();
    check("t5_waitreq_fall", {63'd0, afu_waitrequest}, 64'd0);
    repeat (3) step();
    check("t5_occ_after", {59'd0, occupancy}, 64'd0);

    // 6: read and write together become one write entry
    mem_waitrequest = 1'b1;
    drive(1'b1, 1'b1, 27'h20, 7'd1, 64'h77);
    expect_req(1'b1, 27'h20, 7'd1, 64'h77);
    step();
    idle();
    check("t6_occ", {59'd0, occupancy}, 64'd1);
    check("t6_perr", {63'd0, protocol_err}, 64'd1);
    check("t6_as_write", {62'd0, mem_write, mem_read}, 64'd2);
    mem_waitrequest = 1'b0;
    repeat (3) step();
    check("t6_occ_drained", {59'd0, occupancy}, 64'd0);
    check("final_req_q", 64'(exp_q.size()), 64'd0);
    check("final_resp_q", 64'(resp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
